// File: rtl/xm23_dev_pkg.sv
// Shared XM-23 device definitions: CSR bit positions, arbiter states and default sizing.
package xm23_dev_pkg;

  localparam int NDEV_DEF   = 8;
  localparam int PRIO_W_DEF = 3;

  localparam int CSR_IE  = 0;
  localparam int CSR_DBA = 2;
  localparam int CSR_OF  = 3;
  localparam int CSR_ENA = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CLR  = 2'd2
  } arb_state_e;

  // Vector index width; a single-slot build still needs one bit.
  function automatic int vec_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dev_int_arbiter_if.sv
// CPU-side interrupt handshake: priority in, req/vector out, ack in, DBA-clear strobes out.
interface dev_int_arbiter_if import xm23_dev_pkg::*; #(
  parameter int NDEV   = NDEV_DEF,
  parameter int PRIO_W = PRIO_W_DEF
);
  localparam int VEC_W = vec_width(NDEV);

  logic [PRIO_W-1:0] cpu_prio;
  logic              irq_ack;
  logic              irq_req;
  logic [VEC_W-1:0]  irq_vec;
  logic [NDEV-1:0]   dba_clr;

  modport master (
    input  cpu_prio,
    input  irq_ack,
    output irq_req,
    output irq_vec,
    output dba_clr
  );

  modport slave (
    output cpu_prio,
    output irq_ack,
    input  irq_req,
    input  irq_vec,
    input  dba_clr
  );

endinterface

// File: rtl/dev_prio_select.sv
// Combinational winner selection: highest priority among pending slots, ties resolved
// round-robin starting at rr_ptr and wrapping at NDEV-1.
module dev_prio_select import xm23_dev_pkg::*; #(
  parameter int NDEV   = NDEV_DEF,
  parameter int PRIO_W = PRIO_W_DEF,
  parameter int VEC_W  = vec_width(NDEV)
) (
  input  logic [NDEV-1:0]        pending,
  input  logic [NDEV*PRIO_W-1:0] dev_prio,
  input  logic [VEC_W-1:0]       rr_ptr,
  output logic                   any,
  output logic [VEC_W-1:0]       winner
);

  logic [PRIO_W-1:0] best_prio;
  logic              found;
  logic [VEC_W:0]    slot_sum;
  logic [VEC_W-1:0]  slot;

  // NOTE: every variable written here gets a default before any conditional assignment,
  // otherwise synthesis infers a latch to hold the old value on untaken paths.
  always_comb begin
    any       = 1'b0;
    best_prio = '0;
    winner    = '0;
    found     = 1'b0;
    slot_sum  = '0;
    slot      = '0;

    for (int i = 0; i < NDEV; i++) begin
      if (pending[i] && (!any || dev_prio[PRIO_W*i +: PRIO_W] > best_prio)) begin
        best_prio = dev_prio[PRIO_W*i +: PRIO_W];
        any       = 1'b1;
      end
    end

    // Walk slots from rr_ptr; the first one carrying the top priority wins the tie.
    for (int off = 0; off < NDEV; off++) begin
      slot_sum = {1'b0, rr_ptr} + (VEC_W+1)'(off);
      if (slot_sum >= (VEC_W+1)'(NDEV)) slot_sum = slot_sum - (VEC_W+1)'(NDEV);
      slot = slot_sum[VEC_W-1:0];
      if (!found && pending[slot] && dev_prio[PRIO_W*slot +: PRIO_W] == best_prio) begin
        winner = slot;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dev_int_arbiter.sv
// XM-23 interrupt arbiter: picks the best pending device above CPU priority, runs the
// req/ack handshake and strobes a one-cycle DBA clear to the serviced device.
module dev_int_arbiter import xm23_dev_pkg::*; #(
  parameter int NDEV   = NDEV_DEF,
  parameter int PRIO_W = PRIO_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NDEV*8-1:0]      dev_csr,
  input  logic [NDEV*PRIO_W-1:0] dev_prio,
  dev_int_arbiter_if.master      cpu
);

  localparam int VEC_W = vec_width(NDEV);

  arb_state_e       state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [VEC_W-1:0] rr_q, rr_d;

  logic [NDEV-1:0]  pending;
  logic             any_pending;
  logic [VEC_W-1:0] winner;

  // OF and ENA are software-owned and take no part in arbitration.
  logic [NDEV-1:0]  unused_of_ena;
  logic             unused_csr_bits;
  assign unused_csr_bits = ^dev_csr;

  always_comb begin
    pending       = '0;
    unused_of_ena = '0;
    for (int i = 0; i < NDEV; i++) begin
      pending[i] = dev_csr[8*i + CSR_IE] & dev_csr[8*i + CSR_DBA]
                 & (dev_prio[PRIO_W*i +: PRIO_W] > cpu.cpu_prio);
      unused_of_ena[i] = dev_csr[8*i + CSR_OF] ^ dev_csr[8*i + CSR_ENA];
    end
  end

  dev_prio_select #(
    .NDEV   (NDEV),
    .PRIO_W (PRIO_W),
    .VEC_W  (VEC_W)
  ) u_select (
    .pending  (pending),
    .dev_prio (dev_prio),
    .rr_ptr   (rr_q),
    .any      (any_pending),
    .winner   (winner)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of the order statements execute in.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    rr_d    = rr_q;

    unique case (state_q)
      IDLE: begin
        if (any_pending) begin
          vec_d   = winner;
          state_d = REQ;
        end
      end

      // No preemption while requesting; ack takes precedence over a withdrawal.
      REQ: begin
        if (cpu.irq_ack) begin
          state_d = CLR;
          rr_d    = (vec_q == VEC_W'(NDEV-1)) ? '0 : vec_q + 1'b1;
        end else if (!pending[vec_q]) begin
          state_d = IDLE;
        end
      end

      // One-cycle gap lets the device CSR show the cleared DBA before re-arbitration.
      CLR: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign cpu.irq_req = (state_q == REQ);
  assign cpu.irq_vec = vec_q;
  assign cpu.dba_clr = (state_q == CLR) ? (NDEV'(1) << vec_q) : '0;

endmodule
